hilo_muldiv_unit: RTL
=====================

# hilo_muldiv_unit

Parametrised iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. It sits beside the ALU in EX and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. MFHI and MFLO read the registered `hi`/`lo` outputs directly. It asserts `busy` so the hazard unit can stall EX while a multi-cycle operation is in flight.

## Interface

Parameters:
- `WIDTH`, default 32: operand, HI and LO width. Must be ≥ 4.
- `CNT_W`, default 6: iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: operation issue strobe from EX.
- `op` in 3: operation code.
  - 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO.
  - Codes 7 and 0 are ignored.
- `a` in WIDTH: rs operand (dividend / multiplicand / MTxx data).
- `b` in WIDTH: rt operand (divisor / multiplier).
- `flush` in 1: abort any in-flight operation.
- `busy` out 1: high while an operation is in CALC or FINISH.
- `done` out 1: one-cycle pulse; `hi`/`lo` hold the new result in that cycle.
- `div_by_zero` out 1: one-cycle pulse coincident with `done` for DIV/DIVU with `b`=0.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation

- States: IDLE, CALC, FINISH.
- Reset (asynchronous, any state): state=IDLE, counter=0, `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_by_zero`=0.
- Issue in IDLE, with `start`=1 and `flush`=0:
  - MULT/MULTU/DIV/DIVU: latch operand magnitudes and signs, counter=WIDTH, go to CALC.
  - MTHI: `hi`<=`a`. MTLO: `lo`<=`a`. Both complete in one cycle, with no `busy` and no `done`.
  - NOP: no effect.
- Issue rules outside IDLE:
  - `start` in CALC/FINISH is ignored. The pipeline must stall on `busy`; the bench asserts it never issues while busy.
  - `flush` takes priority over `start` in the same cycle.
- CALC performs one iteration per cycle and decrements the counter; at 0 it goes to FINISH.
  - Multiply: radix-2 shift-add on unsigned magnitudes, giving a 2·WIDTH product.
  - Divide: restoring shift-subtract on unsigned magnitudes, giving a WIDTH quotient and a WIDTH remainder.
- FINISH applies sign correction and writes HI/LO, then returns to IDLE with `done`=1 in the following cycle.
  - MULT: product negated if operand signs differ. HI = upper WIDTH bits, LO = lower WIDTH bits.
  - DIV: quotient truncates toward zero and is negated if signs differ. Remainder takes the dividend's sign. LO = quotient, HI = remainder.
  - Divide by zero (signed or unsigned): LO = all ones, HI = `a`, `div_by_zero`=1.
  - Signed overflow (most-negative / −1): LO = most-negative, HI = 0.
  - Unsigned ops perform no sign correction.
- `flush` in CALC or FINISH: go to IDLE at the next edge. HI/LO are unchanged, and neither `done` nor `div_by_zero` is raised.

## Timing

- Let the `start` sampling edge be cycle 0.
- `busy`=1 in cycles 1..WIDTH+1: CALC for WIDTH cycles, then FINISH for 1 cycle.
- `done`=1 in cycle WIDTH+2 only, with `busy`=0 in that cycle.
- Latency is WIDTH+2 cycles: 34 for WIDTH=32.
- A new `start` is accepted in the `done` cycle (back-to-back issue).
- MTHI/MTLO: the new value is visible on `hi`/`lo` in cycle 1.
- `hi`/`lo` are registered and never change outside MTxx or the `done` transition.
- Flush sampled at edge k (k in 1..WIDTH+1): `busy`=0 from cycle k+1.
- Reset deasserted mid-stream: the unit resumes in IDLE; no partial result is ever written.

## Test plan

- MULT with a=0xFFFFFFFD (−3), b=7, WIDTH=32 -> `done` in cycle 34 with `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
- MULTU with a=b=0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001. Then immediately DIVU a=7, b=2 issued in the `done` cycle -> 34 cycles later `lo`=3, `hi`=1.
- Signed DIV edge cases:
  - a=0xFFFFFFF9 (−7), b=2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - a=0x80000000, b=0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- DIV with a=5, b=0 -> `lo`=0xFFFFFFFF, `hi`=5, `div_by_zero`=1 for exactly one cycle alongside `done`.
- Flush, MTHI and stray start:
  - MTHI a=0x1234 -> `hi`=0x1234 next cycle.
  - MULT 3×4 flushed at cycle 10 -> `busy`=0 at cycle 11, no `done`, `hi`=0x1234, `lo` unchanged.
  - `start` pulses while busy are ignored.
- Async reset: `rst_n` low at cycle 15 of a DIV -> `hi`, `lo`, `busy`, `done` go to 0 without a clock edge; after release, MTLO a=9 gives `lo`=9.

Source files
------------

// File: rtl/hilo_muldiv_unit_if.sv
// rtl/hilo_muldiv_unit_if.sv - EX-stage issue/result bundle for the HI/LO multiply/divide unit
//
// Signals:
//   start        issue strobe from EX
//   op           operation code (0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO)
//   a, b         rs / rt operands
//   flush        abort any in-flight operation
//   busy         operation in flight, EX must stall
//   done         one-cycle pulse, hi/lo hold the new result
//   div_by_zero  one-cycle pulse with done for a zero divisor
//   hi, lo       architectural HI/LO registers
// Modports: master = EX pipeline side, slave = muldiv unit side.
interface hilo_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - iterative multiply/divide unit with HI/LO registers
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    hilo_muldiv_unit_if.slave (start/op/a/b/flush in; busy/done/div_by_zero/hi/lo out)
// Parameters:
//   WIDTH  operand and HI/LO width (>= 4)
//   CNT_W  iteration counter width (2**CNT_W > WIDTH)
module hilo_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hilo_muldiv_unit_if.slave     bus
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINISH} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_dbz;
    // Shared datapath: multiply keeps {partial product, multiplier}, divide keeps
    // {remainder, dividend/quotient}; r_opnd is multiplicand or divisor magnitude.
    logic [WIDTH-1:0]   r_acc_hi;
    logic [WIDTH-1:0]   r_acc_lo;
    logic [WIDTH-1:0]   r_opnd;
    logic               r_is_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_div0;

    logic               w_issue;
    logic               w_arith;
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_sh;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_issue  = (r_state == S_IDLE) && bus.start && !bus.flush;
    assign w_arith  = (bus.op >= OP_MULT) && (bus.op <= OP_DIVU);
    assign w_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign w_a_neg  = w_signed && bus.a[WIDTH-1];
    assign w_b_neg  = w_signed && bus.b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -bus.a : bus.a;
    assign w_b_mag  = w_b_neg ? -bus.b : bus.b;

    // One shift-add step: add multiplicand when the multiplier LSB is set, then
    // shift the whole {sum, multiplier} pair right by one.
    assign w_mul_sum  = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    // One restoring step; the difference fits WIDTH bits whenever it is kept.
    assign w_div_sh   = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_div_ge   = w_div_sh >= {1'b0, r_opnd};
    assign w_div_diff = w_div_sh[WIDTH-1:0] - r_opnd;

    // Magnitude arithmetic already yields most-negative / -1 = most-negative rem 0,
    // and a zero divisor leaves the dividend magnitude as remainder, so only the
    // zero-divisor quotient needs an override; remainder sign restores HI = a.
    assign w_prod     = {r_acc_hi, r_acc_lo};
    assign w_prod_fix = r_neg_res ? -w_prod : w_prod;
    assign w_quo_fix  = r_div0 ? {WIDTH{1'b1}} : (r_neg_res ? -r_acc_lo : r_acc_lo);
    assign w_rem_fix  = r_neg_rem ? -r_acc_hi : r_acc_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_issue && w_arith) w_state_nxt = S_CALC;
            S_CALC:   begin
                if (bus.flush)                   w_state_nxt = S_IDLE;
                else if (r_cnt == CNT_W'(1))     w_state_nxt = S_FINISH;
            end
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_opnd    <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_div0    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        case (bus.op)
                            OP_MTHI: r_hi <= bus.a;
                            OP_MTLO: r_lo <= bus.a;
                            OP_MULT, OP_MULTU: begin
                                r_acc_hi  <= '0;
                                r_acc_lo  <= w_b_mag;
                                r_opnd    <= w_a_mag;
                                r_is_div  <= 1'b0;
                                r_neg_res <= w_a_neg ^ w_b_neg;
                                r_neg_rem <= 1'b0;
                                r_div0    <= 1'b0;
                                r_cnt     <= CNT_W'(WIDTH);
                            end
                            OP_DIV, OP_DIVU: begin
                                r_acc_hi  <= '0;
                                r_acc_lo  <= w_a_mag;
                                r_opnd    <= w_b_mag;
                                r_is_div  <= 1'b1;
                                r_neg_res <= w_a_neg ^ w_b_neg;
                                r_neg_rem <= w_a_neg;
                                r_div0    <= (bus.b == '0);
                                r_cnt     <= CNT_W'(WIDTH);
                            end
                            default: ;
                        endcase
                    end
                end
                S_CALC: begin
                    if (bus.flush) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_is_div) begin
                            r_acc_hi <= w_div_ge ? w_div_diff : w_div_sh[WIDTH-1:0];
                            r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_div_ge};
                        end else begin
                            r_acc_hi <= w_mul_sum[WIDTH:1];
                            r_acc_lo <= {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
                        end
                    end
                end
                S_FINISH: begin
                    if (!bus.flush) begin
                        if (r_is_div) begin
                            r_lo <= w_quo_fix;
                            r_hi <= w_rem_fix;
                        end else begin
                            r_lo <= w_prod_fix[WIDTH-1:0];
                            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        end
                        r_done <= 1'b1;
                        r_dbz  <= r_is_div && r_div0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;
endmodule
